vote_session_n: RTL
===================

Name: vote_session_n

Overview:
- Parametrised, clocked successor to the five-input majority voter.
- Runs a voting session for N voters: opens on START and captures each voter's first vote.
- Closes when every voter has voted or a timeout expires, then registers the majority result, yes-count and abstain-count.
- Sits between debounced voter-button inputs and the display/LED output stage.

Parameters:
- N, 5, number of voters (2..16).
- THRESH, 3, minimum yes-votes for Y=1; legal range 1..N.
- TIMEOUT, 16, maximum COLLECT cycles per session (>=1).
- CW, 3, count width; must satisfy 2^CW > N.
- TW, 5, timer width; must satisfy 2^TW >= TIMEOUT.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  opens a session; sampled only in IDLE.
- VOTE_EN  in  N  per-voter vote strobe/level; bit i=1 means voter i is casting a vote this cycle.
- VOTE_VAL  in  N  per-voter choice, 1=yes, 0=no; qualified by VOTE_EN[i].
- BUSY  out  1  high while the session is open (COLLECT or RESULT).
- DONE  out  1  one-cycle pulse when results update.
- VALID  out  1  high from DONE until the next accepted START.
- Y  out  1  decision: yes-count >= THRESH.
- COUNT  out  CW  number of yes votes.
- ABST  out  CW  number of voters that never voted.

Behaviour:
- Reset: RST=1 asynchronously forces the following, with no DONE generated:
  - state=IDLE;
  - voted/choice/timer registers=0;
  - BUSY=DONE=VALID=Y=0, COUNT=ABST=0.
- States are IDLE, COLLECT and RESULT; all outputs are registered.
- IDLE:
  - BUSY=0.
  - START=1 at an edge → COLLECT. The same edge clears voted[], choice[], timer, VALID, Y, COUNT and ABST.
  - VOTE_EN is ignored in IDLE.
- COLLECT:
  - BUSY=1.
  - At each edge, for every i with VOTE_EN[i]=1 and voted[i]=0: voted[i]<=1 and choice[i]<=VOTE_VAL[i].
  - Once voted[i]=1, further VOTE_EN[i]/VOTE_VAL[i] are ignored (first vote wins, no revoting). Multiple voters may vote in the same cycle.
  - timer increments once per COLLECT cycle.
  - Exit to RESULT at the edge where either condition holds (evaluated on voted_next, so votes captured on that same edge count):
    - all bits of voted_next=1, or
    - timer==TIMEOUT-1.
  - So COLLECT lasts at most TIMEOUT cycles. If both conditions hold at once, the result is identical.
- RESULT: lasts exactly one cycle. At its closing edge:
  - COUNT<=popcount(choice);
  - ABST<=N-popcount(voted);
  - Y<=(popcount(choice)>=THRESH);
  - DONE<=1 for one cycle; VALID<=1;
  - state<=IDLE.
- Latency: the last vote is captured at edge t, and outputs/DONE are visible after edge t+1.
- Non-voters count as neither yes nor no; they affect only ABST. The threshold is absolute, not relative to turnout.
- START while BUSY=1 is ignored. START held high continuously restarts a session on the first IDLE edge after DONE.
- Arithmetic: popcount is CW bits wide and cannot overflow given 2^CW>N; the comparison is unsigned.
- Out-of-range parameters (THRESH=0 or THRESH>N, 2^CW<=N) are illegal and are flagged by an elaboration-time check.

Test Plan (N=5, THRESH=3, TIMEOUT=16):
- Yes majority: RST pulse, START; next cycle VOTE_EN=5'b11111, VOTE_VAL=5'b10011 → after 1 cycle DONE=1 for one cycle, Y=1, COUNT=3, ABST=0, VALID=1, BUSY=0.
- No majority: START; VOTE_EN=5'b11111, VOTE_VAL=5'b01100 → Y=0, COUNT=2, ABST=0.
- Timeout: START; only voters 0,1 vote yes in COLLECT cycle 1 → DONE exactly 16 COLLECT cycles plus 1 RESULT cycle after entering COLLECT, with Y=0, COUNT=2, ABST=3.
- First vote wins: START; voter 0 votes yes; two cycles later voter 0 votes no and voters 1..4 vote yes,yes,no,no → Y=1, COUNT=3; the repeat vote is ignored.
- Reset mid-session: START, voters 0,1 vote; RST asserted asynchronously mid-cycle → all outputs 0 immediately, no DONE pulse. A new START plus five yes votes → Y=1, COUNT=5.
- START handling: START pulsed repeatedly during COLLECT → no restart, session ends normally. VALID=1 after DONE drops to 0 at the next accepted START edge, together with Y/COUNT/ABST clearing.

Source files
------------

// File: rtl/vote_session_n.sv
// N-voter session controller: opens on START, captures each voter's first vote,
// closes on full turnout or timeout and registers majority, yes-count and abstain-count.
module vote_session_n #(
   parameter int N       = 5,
   parameter int THRESH  = 3,
   parameter int TIMEOUT = 16,
   parameter int CW      = 3,
   parameter int TW      = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [N-1:0]  VOTE_EN,
   input  logic [N-1:0]  VOTE_VAL,
   output logic          BUSY,
   output logic          DONE,
   output logic          VALID,
   output logic          Y,
   output logic [CW-1:0] COUNT,
   output logic [CW-1:0] ABST
);

   // state   | meaning
   // IDLE    | waiting for START, last result held
   // COLLECT | capturing first votes, timer running
   // RESULT  | one cycle, results registered on its closing edge
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RESULT} state_t;

   if (N < 2 || N > 16) begin : g_bad_n
      $error("vote_session_n: N must be 2..16");
   end
   if (THRESH < 1 || THRESH > N) begin : g_bad_thresh
      $error("vote_session_n: THRESH must be 1..N");
   end
   if ((1 << CW) <= N) begin : g_bad_cw
      $error("vote_session_n: 2^CW must exceed N");
   end
   if (TIMEOUT < 1 || (1 << TW) < TIMEOUT) begin : g_bad_tw
      $error("vote_session_n: TIMEOUT must be >=1 and fit in TW bits");
   end

   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   state_t        state_q, state_d;
   logic [N-1:0]  voted_q, voted_d, choice_q, choice_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          busy_q, busy_d, done_q, done_d, valid_q, valid_d, y_q, y_d;
   logic [CW-1:0] count_q, count_d, abst_q, abst_d;
   logic [N-1:0]  new_votes;
   logic [CW-1:0] yes_cnt, voted_cnt;

   assign new_votes = VOTE_EN & ~voted_q;
   assign yes_cnt   = popcount(choice_q);
   assign voted_cnt = popcount(voted_q);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         voted_q  <= '0;
         choice_q <= '0;
         timer_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         y_q      <= 1'b0;
         count_q  <= '0;
         abst_q   <= '0;
      end else begin
         state_q  <= state_d;
         voted_q  <= voted_d;
         choice_q <= choice_d;
         timer_q  <= timer_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         y_q      <= y_d;
         count_q  <= count_d;
         abst_q   <= abst_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      voted_d  = voted_q;
      choice_d = choice_q;
      timer_d  = timer_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d  = S_COLLECT;
               voted_d  = '0;
               choice_d = '0;
               timer_d  = '0;
            end
         end
         S_COLLECT: begin
            voted_d  = voted_q | new_votes;
            choice_d = (choice_q & ~new_votes) | (VOTE_VAL & new_votes);
            timer_d  = timer_q + TW'(1);
            // Exit on voted_d so votes landing on the closing edge still count.
            if ((&voted_d) || (timer_q == TIMER_LAST)) state_d = S_RESULT;
         end
         S_RESULT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d  = (state_d != S_IDLE);
      done_d  = 1'b0;
      valid_d = valid_q;
      y_d     = y_q;
      count_d = count_q;
      abst_d  = abst_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               valid_d = 1'b0;
               y_d     = 1'b0;
               count_d = '0;
               abst_d  = '0;
            end
         end
         S_RESULT: begin
            done_d  = 1'b1;
            valid_d = 1'b1;
            count_d = yes_cnt;
            abst_d  = CW'(N) - voted_cnt;
            y_d     = (yes_cnt >= CW'(THRESH));
         end
         default: ;
      endcase
   end

   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign VALID = valid_q;
   assign Y     = y_q;
   assign COUNT = count_q;
   assign ABST  = abst_q;

endmodule
